// File: rtl/uart_rx_pkg.sv
// Shared encodings for the UART RX frame sequencer: FSM states, prescale codes
// and the prescale-code to oversampling-ratio mapping.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic [1:0] CLOCK_8  = 2'b00;
    localparam logic [1:0] CLOCK_16 = 2'b01;
    localparam logic [1:0] CLOCK_32 = 2'b10;

    // The reserved code 2'b11 falls back to x8.
    function automatic logic [5:0] ratio(input logic [1:0] code);
        case (code)
            CLOCK_16: ratio = 6'd16;
            CLOCK_32: ratio = 6'd32;
            default:  ratio = 6'd8;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Edge-within-bit and bit-within-byte counters; edge counter held at 0 while
// disabled, both wrap at their programmed last value. Zero latency, no backpressure.
module uart_rx_edge_bit_counter #(
    parameter int EDGE_CNT_WIDTH = 6,
    parameter int BIT_CNT_WIDTH  = 3,
    parameter int BIT_LAST       = 7
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [EDGE_CNT_WIDTH-1:0] last_edge,
    input  logic                      bit_inc,
    input  logic                      bit_clr,
    output logic [EDGE_CNT_WIDTH-1:0] edge_counter,
    output logic [BIT_CNT_WIDTH-1:0]  bit_counter,
    output logic                      edge_last
);

    assign edge_last = (edge_counter == last_edge);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            edge_counter <= '0;
        end else if (!enable || edge_last) begin
            edge_counter <= '0;
        end else begin
            edge_counter <= edge_counter + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bit_counter <= '0;
        end else if (bit_clr) begin
            bit_counter <= '0;
        end else if (bit_inc) begin
            if (bit_counter == BIT_CNT_WIDTH'(BIT_LAST)) bit_counter <= '0;
            else                                           bit_counter <= bit_counter + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_controller.sv
// UART RX frame sequencer: start detect, LSB-first deserialize, parity/stop check; pulses
// land P*(10+parity_enable) edges after start detect. Optional UART_RX_ERR_CNT_EN adds err_count.
module uart_rx_controller
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int EDGE_CNT_WIDTH = 6
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      rx_in,
    input  logic [1:0]                prescale,
    input  logic                      parity_enable,
    input  logic                      parity_type,
    input  logic                      sampled_bit,
    output logic [EDGE_CNT_WIDTH-1:0] edge_counter,
    output logic                      sample_enable,
    output logic                      busy,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic                      data_valid,
    output logic                      parity_error,
    output logic                      stop_error
`ifdef UART_RX_ERR_CNT_EN
    ,
    input  logic                      err_count_clr,
    output logic [7:0]                err_count
`endif
);

    localparam int BIT_CNT_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    state_t                      state;
    logic [1:0]                  prescale_q;
    logic                        parity_enable_q;
    logic                        parity_type_q;
    logic [DATA_WIDTH-1:0]       shift;
    logic                        parity_err_r;
    logic [BIT_CNT_WIDTH-1:0]    bit_counter;
    logic [EDGE_CNT_WIDTH-1:0]   last_edge;
    logic                        eval;
    logic                        last_bit;

    assign last_edge     = EDGE_CNT_WIDTH'(ratio(prescale_q) - 6'd1);
    assign last_bit      = (bit_counter == BIT_CNT_WIDTH'(DATA_WIDTH - 1));
    assign busy          = (state != ST_IDLE);
    assign sample_enable = (state != ST_IDLE);

    uart_rx_edge_bit_counter #(
        .EDGE_CNT_WIDTH (EDGE_CNT_WIDTH),
        .BIT_CNT_WIDTH  (BIT_CNT_WIDTH),
        .BIT_LAST       (DATA_WIDTH - 1)
    ) u_counter (
        .clock        (clock),
        .reset        (reset),
        .enable       (busy),
        .last_edge    (last_edge),
        .bit_inc      ((state == ST_DATA) && eval),
        .bit_clr      (state == ST_START),
        .edge_counter (edge_counter),
        .bit_counter  (bit_counter),
        .edge_last    (eval)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= ST_IDLE;
            prescale_q      <= CLOCK_8;
            parity_enable_q <= 1'b0;
            parity_type_q   <= 1'b0;
            shift           <= '0;
            parity_err_r    <= 1'b0;
            data_out        <= '0;
            data_valid      <= 1'b0;
            parity_error    <= 1'b0;
            stop_error      <= 1'b0;
        end else begin
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Frame configuration is frozen here for the whole frame.
                    if (!rx_in) begin
                        state           <= ST_START;
                        prescale_q      <= prescale;
                        parity_enable_q <= parity_enable;
                        parity_type_q   <= parity_type;
                    end
                end
                ST_START: begin
                    if (eval) state <= sampled_bit ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (eval) begin
                        shift <= {sampled_bit, shift[DATA_WIDTH-1:1]};
                        if (last_bit) state <= parity_enable_q ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    if (eval) begin
                        parity_err_r <= sampled_bit != (parity_type_q ? ~^shift : ^shift);
                        state        <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (eval) begin
                        parity_error <= parity_err_r;
                        stop_error   <= ~sampled_bit;
                        if (!parity_err_r && sampled_bit) begin
                            data_out   <= shift;
                            data_valid <= 1'b1;
                        end
                        parity_err_r <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    logic err_event;

    assign err_event = eval && (((state == ST_START) && sampled_bit) ||
                                ((state == ST_STOP) && (parity_err_r || !sampled_bit)));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_count <= 8'd0;
        end else if (err_count_clr) begin
            err_count <= 8'd0;
        end else if (err_event && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed table-driven bench for uart_rx_controller plus start-glitch and mid-frame reset sequences.
module tb_uart_rx_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       rx_in;
    logic [1:0] prescale;
    logic       parity_enable;
    logic       parity_type;
    logic       sampled_bit;
    logic [5:0] edge_counter;
    logic       sample_enable;
    logic       busy;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_error;
    logic       stop_error;
`ifdef UART_RX_ERR_CNT_EN
    logic       err_count_clr;
    logic [7:0] err_count;
    int         exp_err = 0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    uart_rx_controller dut (
        .clock         (clock),
        .reset         (reset),
        .rx_in         (rx_in),
        .prescale      (prescale),
        .parity_enable (parity_enable),
        .parity_type   (parity_type),
        .sampled_bit   (sampled_bit),
        .edge_counter  (edge_counter),
        .sample_enable (sample_enable),
        .busy          (busy),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .parity_error  (parity_error),
        .stop_error    (stop_error)
`ifdef UART_RX_ERR_CNT_EN
        ,
        .err_count_clr (err_count_clr),
        .err_count     (err_count)
`endif
    );

    typedef struct {
        logic [1:0] pre;
        logic       pen;
        logic       ptype;
        logic [7:0] data;
        logic       pflip;
        logic       stopb;
        int         exp_end;
        int         exp_dv;
        int         exp_pe;
        int         exp_se;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int ratio_of(input logic [1:0] pre);
        return (pre == 2'b01) ? 16 : (pre == 2'b10) ? 32 : 8;
    endfunction

    // Start bit covers edges 0..P, bit j>0 covers edges jP+1..(j+1)P, idle high afterwards.
    function automatic logic line_at(input logic [11:0] fr, input int nb, input int p, input int k);
        int idx;
        idx = (k == 0) ? 0 : (k - 1) / p;
        return (idx < nb) ? fr[idx] : 1'b1;
    endfunction

    task automatic build(input vec_t v, output logic [11:0] fr, output int nb);
        logic par;
        par = (v.ptype ? ~^v.data : ^v.data) ^ v.pflip;
        fr  = 12'h000;
        for (int i = 0; i < 8; i++) fr[1+i] = v.data[i];
        nb = 9;
        if (v.pen) begin
            fr[nb] = par;
            nb++;
        end
        fr[nb] = v.stopb;
        nb++;
    endtask

    task automatic run_frame(input string tag, input vec_t v);
        logic [11:0] fr;
        int nb, p, first, dv_n, pe_n, se_n, busy_bad, ec_bad, exp_ec;
        logic exp_busy, line;
        build(v, fr, nb);
        p = ratio_of(v.pre);
        prescale = v.pre; parity_enable = v.pen; parity_type = v.ptype;
        first = -1; dv_n = 0; pe_n = 0; se_n = 0; busy_bad = 0; ec_bad = 0;
        for (int k = 0; k <= v.exp_end + 3; k++) begin
            line = line_at(fr, nb, p, k);
            rx_in = line; sampled_bit = line;
            if (k == 1) begin
                prescale = ~v.pre; parity_enable = ~v.pen; parity_type = ~v.ptype;
            end
            @(posedge clock); #1;
            if (data_valid)   dv_n++;
            if (parity_error) pe_n++;
            if (stop_error)   se_n++;
            if ((data_valid || parity_error || stop_error) && first < 0) first = k;
            exp_busy = (k < v.exp_end);
            if (busy !== exp_busy || sample_enable !== exp_busy) busy_bad++;
            exp_ec = (k <= v.exp_end) ? (k % p) : 0;
            if (edge_counter !== 6'(exp_ec)) ec_bad++;
        end
        rx_in = 1'b1; sampled_bit = 1'b1;
        check({tag, "_dv_count"}, dv_n, v.exp_dv);
        check({tag, "_pe_count"}, pe_n, v.exp_pe);
        check({tag, "_se_count"}, se_n, v.exp_se);
        check({tag, "_pulse_edge"}, first, v.exp_end);
        check({tag, "_data_out"}, {24'd0, data_out}, {24'd0, v.exp_dout});
        check({tag, "_busy_profile_bad"}, busy_bad, 0);
        check({tag, "_edge_counter_bad"}, ec_bad, 0);
`ifdef UART_RX_ERR_CNT_EN
        if (v.exp_pe != 0 || v.exp_se != 0) exp_err++;
        check({tag, "_err_count"}, {24'd0, err_count}, exp_err);
`endif
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        int busy_fall, pulses;
        logic [11:0] fr;
        int nb;
        vec_t rv;

        //          pre    pen   ptype data   flip  stop  end  dv pe se dout
        vecs[0] = '{2'd0, 1'b1, 1'b0, 8'hB5, 1'b0, 1'b1, 88,  1, 0, 0, 8'hB5};
        vecs[1] = '{2'd1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 160, 1, 0, 0, 8'h3C};
        vecs[2] = '{2'd0, 1'b1, 1'b1, 8'hB5, 1'b1, 1'b1, 88,  0, 1, 0, 8'h3C};
        vecs[3] = '{2'd2, 1'b0, 1'b0, 8'hA7, 1'b0, 1'b0, 320, 0, 0, 1, 8'h3C};
        vecs[4] = '{2'd3, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 80,  1, 0, 0, 8'h81};

        reset = 1'b0; rx_in = 1'b1; sampled_bit = 1'b1;
        prescale = 2'd0; parity_enable = 1'b0; parity_type = 1'b0;
`ifdef UART_RX_ERR_CNT_EN
        err_count_clr = 1'b0;
`endif
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", busy, 0);
        check("rst_sample_enable", sample_enable, 0);
        check("rst_edge_counter", edge_counter, 0);
        check("rst_data_out", data_out, 0);
        check("rst_pulses", {data_valid, parity_error, stop_error}, 0);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;

        for (int i = 0; i < 5; i++) run_frame($sformatf("vec%0d", i), vecs[i]);

        // Two-cycle low glitch at x8: START must abort on edge 8.
        prescale = 2'd0; parity_enable = 1'b0; busy_fall = -1; pulses = 0;
        for (int k = 0; k < 14; k++) begin
            rx_in = (k < 2) ? 1'b0 : 1'b1;
            sampled_bit = rx_in;
            @(posedge clock); #1;
            if (data_valid || parity_error || stop_error) pulses++;
            if (!busy && busy_fall < 0) busy_fall = k;
        end
        check("glitch_busy_fall_edge", busy_fall, 8);
        check("glitch_pulses", pulses, 0);
        check("glitch_data_out", data_out, 8'h81);
`ifdef UART_RX_ERR_CNT_EN
        exp_err++;
        check("glitch_err_count", err_count, exp_err);
        err_count_clr = 1'b1;
        @(posedge clock); #1;
        err_count_clr = 1'b0;
        exp_err = 0;
        check("err_count_clr", err_count, 0);
`endif

        // Reset in the middle of the DATA phase, then a clean frame.
        rv = '{2'd0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 80, 1, 0, 0, 8'h5A};
        build(rv, fr, nb);
        prescale = 2'd0; parity_enable = 1'b0; parity_type = 1'b0;
        for (int k = 0; k <= 30; k++) begin
            rx_in = line_at(fr, nb, 8, k);
            sampled_bit = rx_in;
            @(posedge clock); #1;
        end
        check("mid_busy_before_reset", busy, 1);
        reset = 1'b0;
        #2;
        check("midrst_busy", busy, 0);
        check("midrst_edge_counter", edge_counter, 0);
        check("midrst_data_out", data_out, 0);
        rx_in = 1'b1; sampled_bit = 1'b1;
        pulses = 0;
        repeat (3) begin
            @(posedge clock); #1;
            if (data_valid || parity_error || stop_error || busy || sample_enable) pulses++;
        end
        check("midrst_held_quiet", pulses, 0);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        run_frame("after_reset", rv);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
